// File: rtl/noise_filter_bank_pkg.sv
// Shared helpers for the noise_filter_bank block family.
// Width arithmetic used by the bank, its channels and the bus interface.
package noise_filter_bank_pkg;

    // Ceiling log2; clog2(1) == 0.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/noise_filter_bank_if.sv
// Input/output bundle of the noise_filter_bank glitch filter.
// master drives the raw inputs and controls; slave is the filter bank.
interface noise_filter_bank_if
    import noise_filter_bank_pkg::*;
#(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned MAX_LEN  = 15,
    parameter int unsigned GLITCH_W = 16
);
    localparam int unsigned LW = clog2(MAX_LEN + 1);

    logic [CHANNELS-1:0] q;
    logic [LW-1:0]       len;
    logic                glitch_clr;
    logic [CHANNELS-1:0] ql;
    logic [CHANNELS-1:0] rise;
    logic [CHANNELS-1:0] fall;
    logic [GLITCH_W-1:0] glitch_cnt;

    modport master (
        output q, len, glitch_clr,
        input  ql, rise, fall, glitch_cnt
    );

    modport slave (
        input  q, len, glitch_clr,
        output ql, rise, fall, glitch_cnt
    );

endinterface

// File: rtl/noise_filter_chan.sv
// One glitch-filter channel: synchroniser, input register, hold counter,
// filtered level with edge pulses, and a reject strobe for the parent.
module noise_filter_chan
    import noise_filter_bank_pkg::*;
#(
    parameter int unsigned MAX_LEN = 15,
    parameter int unsigned SYNC    = 2,
    parameter int unsigned LW      = clog2(MAX_LEN + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          q,
    input  logic [LW-1:0] l,
    output logic          ql,
    output logic          rise,
    output logic          fall,
    output logic          reject
);
    localparam int unsigned CW = (MAX_LEN > 1) ? clog2(MAX_LEN) : 1;

    logic          s;
    logic [CW-1:0] cnt;
    logic          differ;
    logic          at_end;

    // Synchroniser chain followed by the input register s.
    if (SYNC == 0) begin : g_nosync
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s <= 1'b0;
            end else begin
                s <= q;
            end
        end
    end else begin : g_sync
        logic [SYNC-1:0] sync_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync_q <= '0;
                s      <= 1'b0;
            end else begin
                sync_q[0] <= q;
                for (int i = 1; i < int'(SYNC); i++) begin
                    sync_q[i] <= sync_q[i-1];
                end
                s <= sync_q[SYNC-1];
            end
        end
    end

    // l is already clamped to 1..MAX_LEN; >= lets a lowered length commit at once.
    assign differ = s ^ ql;
    assign at_end = LW'(cnt) >= (l - LW'(1));
    assign reject = ~differ & (cnt != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ql   <= 1'b0;
            cnt  <= '0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (differ) begin
                if (at_end) begin
                    ql   <= s;
                    cnt  <= '0;
                    rise <= s;
                    fall <= ~s;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else if (cnt != '0) begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/noise_filter_bank.sv
// Multi-channel programmable glitch filter with edge pulses and a shared
// saturating count of rejected glitches.
module noise_filter_bank
    import noise_filter_bank_pkg::*;
#(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned MAX_LEN  = 15,
    parameter int unsigned SYNC     = 2,
    parameter int unsigned GLITCH_W = 16
) (
    input logic               clk,
    input logic               rst,
    noise_filter_bank_if.slave bus
);
    localparam int unsigned LW = clog2(MAX_LEN + 1);
    localparam int unsigned PW = clog2(CHANNELS + 1);
    localparam int unsigned SW = max_u(GLITCH_W, PW) + 1;
    localparam logic [SW-1:0] GMAX = SW'({GLITCH_W{1'b1}});

    logic [LW-1:0]       l_eff;
    logic [CHANNELS-1:0] ql_w;
    logic [CHANNELS-1:0] rise_w;
    logic [CHANNELS-1:0] fall_w;
    logic [CHANNELS-1:0] rej_w;
    logic [PW-1:0]       pop;
    logic [SW-1:0]       sum;
    logic [GLITCH_W-1:0] glitch_next;
    logic [GLITCH_W-1:0] glitch_q;

    // Clamp the shared length into 1..MAX_LEN once for all channels.
    always_comb begin
        l_eff = bus.len;
        if (bus.len == '0) begin
            l_eff = LW'(1);
        end else if ({1'b0, bus.len} > (LW + 1)'(MAX_LEN)) begin
            l_eff = LW'(MAX_LEN);
        end
    end

    for (genvar i = 0; i < int'(CHANNELS); i++) begin : g_chan
        noise_filter_chan #(
            .MAX_LEN (MAX_LEN),
            .SYNC    (SYNC),
            .LW      (LW)
        ) u_chan (
            .clk    (clk),
            .rst    (rst),
            .q      (bus.q[i]),
            .l      (l_eff),
            .ql     (ql_w[i]),
            .rise   (rise_w[i]),
            .fall   (fall_w[i]),
            .reject (rej_w[i])
        );
    end

    // Popcount of this cycle's rejections added with saturation.
    always_comb begin
        pop = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            pop = pop + PW'(rej_w[i]);
        end
        sum         = SW'(glitch_q) + SW'(pop);
        glitch_next = (sum > GMAX) ? {GLITCH_W{1'b1}} : sum[GLITCH_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            glitch_q <= '0;
        end else if (bus.glitch_clr) begin
            glitch_q <= '0;
        end else begin
            glitch_q <= glitch_next;
        end
    end

    assign bus.ql         = ql_w;
    assign bus.rise       = rise_w;
    assign bus.fall       = fall_w;
    assign bus.glitch_cnt = glitch_q;

endmodule
